// File: rtl/vga_fb_pkg.sv
// Shared definitions for the 80x60 framebuffer: geometry, field widths,
// fill-controller state encoding and the {Y, X} address packing.
package vga_fb_pkg;

  localparam int NUM_COLS = 80;
  localparam int NUM_ROWS = 60;
  localparam int X_W      = 7;
  localparam int Y_W      = 6;
  localparam int ADDR_W   = X_W + Y_W;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(
    input logic [Y_W-1:0] y,
    input logic [X_W-1:0] x
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/vga_rect_scanner.sv
// Rectangle cursor: latches clipped bounds on load and walks them row-major,
// one pixel per advance, flagging the final (X1,Y1) position.
module vga_rect_scanner
  import vga_fb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_load,
  input  logic              i_advance,
  input  logic [X_W-1:0]    i_x0,
  input  logic [X_W-1:0]    i_x1,
  input  logic [Y_W-1:0]    i_y0,
  input  logic [Y_W-1:0]    i_y1,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [X_W-1:0] r_x0;
  logic [X_W-1:0] r_x1;
  logic [Y_W-1:0] r_y1;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_row_end;

  assign w_row_end = (r_x == r_x1);

  // cursor stage: X and Y are independent counters, Y only moves on the X wrap
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_x0 <= i_x0;
      r_x1 <= i_x1;
      r_y1 <= i_y1;
      r_x  <= i_x0;
      r_y  <= i_y0;
    end else if (i_advance) begin
      if (w_row_end) begin
        r_x <= r_x0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_addr = pack_addr(r_y, r_x);
  assign o_last = w_row_end && (r_y == r_y1);

endmodule

// File: rtl/vga_fb_write_ctrl.sv
// Single framebuffer write port shared between MCU pixel writes (fixed
// priority) and the rectangle-fill engine, with fully registered outputs.
module vga_fb_write_ctrl
  import vga_fb_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MCU_WE,
  input  logic [ADDR_W-1:0] MCU_WA,
  input  logic [7:0]        MCU_WD,
  input  logic              FILL_START,
  input  logic [X_W-1:0]    FILL_X0,
  input  logic [X_W-1:0]    FILL_X1,
  input  logic [Y_W-1:0]    FILL_Y0,
  input  logic [Y_W-1:0]    FILL_Y1,
  input  logic [7:0]        FILL_COLOR,
  output logic              FILL_BUSY,
  output logic              FILL_DONE,
  output logic              FB_WE,
  output logic [ADDR_W-1:0] FB_WA,
  output logic [7:0]        FB_WD
);

  localparam logic [X_W-1:0] X_MAX = X_W'(NUM_COLS - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(NUM_ROWS - 1);

  function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] x);
    return (x > X_MAX) ? X_MAX : x;
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] y);
    return (y > Y_MAX) ? Y_MAX : y;
  endfunction

  fill_state_e       r_state;
  fill_state_e       w_state_nxt;
  logic [7:0]        r_color;
  logic [X_W-1:0]    w_x1_clip;
  logic [Y_W-1:0]    w_y1_clip;
  logic              w_empty;
  logic              w_load;
  logic              w_advance;
  logic [ADDR_W-1:0] w_scan_addr;
  logic              w_scan_last;

  logic              w_we_p0;
  logic [ADDR_W-1:0] w_wa_p0;
  logic [7:0]        w_wd_p0;
  logic              w_done_p0;
  logic              w_busy_p0;

  logic              r_we_p1;
  logic [ADDR_W-1:0] r_wa_p1;
  logic [7:0]        r_wd_p1;
  logic              r_done_p1;
  logic              r_busy_p1;

  // Out-of-range starts fall out of the same compare: X0>=80 always exceeds
  // the clamped X1, likewise for Y.
  assign w_x1_clip = clamp_x(FILL_X1);
  assign w_y1_clip = clamp_y(FILL_Y1);
  assign w_empty   = (FILL_X0 > w_x1_clip) || (FILL_Y0 > w_y1_clip);

  vga_rect_scanner u_scanner (
    .i_clk     (CLK),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_x0      (FILL_X0),
    .i_x1      (w_x1_clip),
    .i_y0      (FILL_Y0),
    .i_y1      (w_y1_clip),
    .o_addr    (w_scan_addr),
    .o_last    (w_scan_last)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_load) begin
      r_color <= FILL_COLOR;
    end
  end

  // p0: arbitration and next state; the MCU always wins the port
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_done_p0   = 1'b0;
    w_we_p0     = 1'b0;
    w_wa_p0     = r_wa_p1;
    w_wd_p0     = r_wd_p1;

    if (MCU_WE) begin
      w_we_p0 = 1'b1;
      w_wa_p0 = MCU_WA;
      w_wd_p0 = MCU_WD;
    end

    case (r_state)
      IDLE: begin
        if (FILL_START) begin
          if (w_empty) begin
            w_done_p0 = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = FILL;
          end
        end
      end
      FILL: begin
        if (!MCU_WE) begin
          w_we_p0   = 1'b1;
          w_wa_p0   = w_scan_addr;
          w_wd_p0   = r_color;
          w_advance = 1'b1;
          if (w_scan_last) begin
            w_state_nxt = IDLE;
            w_done_p0   = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_p0 = (w_state_nxt == FILL);
  end

  // p1: registered framebuffer port and status flags
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_we_p1   <= 1'b0;
      r_wa_p1   <= '0;
      r_wd_p1   <= '0;
      r_done_p1 <= 1'b0;
      r_busy_p1 <= 1'b0;
    end else begin
      r_we_p1   <= w_we_p0;
      r_wa_p1   <= w_wa_p0;
      r_wd_p1   <= w_wd_p0;
      r_done_p1 <= w_done_p0;
      r_busy_p1 <= w_busy_p0;
    end
  end

  assign FB_WE     = r_we_p1;
  assign FB_WA     = r_wa_p1;
  assign FB_WD     = r_wd_p1;
  assign FILL_DONE = r_done_p1;
  assign FILL_BUSY = r_busy_p1;

endmodule

// File: tb/tb_vga_fb_write_ctrl.sv
// Directed bench for vga_fb_write_ctrl: per-cycle vector table plus
// hand-written contention, reset-abort and restart-while-busy sequences.
module tb_vga_fb_write_ctrl;

  logic        CLK;
  logic        RESET;
  logic        MCU_WE;
  logic [12:0] MCU_WA;
  logic [7:0]  MCU_WD;
  logic        FILL_START;
  logic [6:0]  FILL_X0;
  logic [6:0]  FILL_X1;
  logic [5:0]  FILL_Y0;
  logic [5:0]  FILL_Y1;
  logic [7:0]  FILL_COLOR;
  logic        FILL_BUSY;
  logic        FILL_DONE;
  logic        FB_WE;
  logic [12:0] FB_WA;
  logic [7:0]  FB_WD;

  int n_cmp;
  int n_fail;

  vga_fb_write_ctrl dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .MCU_WE     (MCU_WE),
    .MCU_WA     (MCU_WA),
    .MCU_WD     (MCU_WD),
    .FILL_START (FILL_START),
    .FILL_X0    (FILL_X0),
    .FILL_X1    (FILL_X1),
    .FILL_Y0    (FILL_Y0),
    .FILL_Y1    (FILL_Y1),
    .FILL_COLOR (FILL_COLOR),
    .FILL_BUSY  (FILL_BUSY),
    .FILL_DONE  (FILL_DONE),
    .FB_WE      (FB_WE),
    .FB_WA      (FB_WA),
    .FB_WD      (FB_WD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        mwe;
    logic [12:0] mwa;
    logic [7:0]  mwd;
    logic        fs;
    logic [6:0]  x0;
    logic [6:0]  x1;
    logic [5:0]  y0;
    logic [5:0]  y1;
    logic [7:0]  col;
    logic        ewe;
    logic [12:0] ewa;
    logic [7:0]  ewd;
    logic        ebusy;
    logic        edone;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, then pulses drop.
  task automatic cyc(input string nm, input logic ewe, input logic [12:0] ewa,
                     input logic [7:0] ewd, input logic ebusy, input logic edone);
    @(posedge CLK);
    #1;
    check({nm, ".we"}, int'(FB_WE), int'(ewe));
    if (ewe) begin
      check({nm, ".wa"}, int'(FB_WA), int'(ewa));
      check({nm, ".wd"}, int'(FB_WD), int'(ewd));
    end
    check({nm, ".busy"}, int'(FILL_BUSY), int'(ebusy));
    check({nm, ".done"}, int'(FILL_DONE), int'(edone));
    MCU_WE     = 1'b0;
    FILL_START = 1'b0;
  endtask

  task automatic set_fill(input logic [6:0] x0, input logic [6:0] x1,
                          input logic [5:0] y0, input logic [5:0] y1, input logic [7:0] col);
    FILL_START = 1'b1;
    FILL_X0    = x0;
    FILL_X1    = x1;
    FILL_Y0    = y0;
    FILL_Y1    = y1;
    FILL_COLOR = col;
  endtask

  initial begin
    int nw;
    n_cmp  = 0;
    n_fail = 0;

    //         mwe  mwa       mwd    fs   x0     x1      y0    y1    col    ewe  ewa       ewd    busy done
    tbl[0]  = '{1'b1, 13'h0A05, 8'hE0, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b1, 13'h0A05, 8'hE0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 13'h0000, 8'h00, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 13'h0000, 8'h00, 1'b1, 7'd2,  7'd4,   6'd3, 6'd4, 8'h1C, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 13'h0000, 8'h00, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b1, 13'h0182, 8'h1C, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 13'h0000, 8'h00, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b1, 13'h0183, 8'h1C, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 13'h0000, 8'h00, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b1, 13'h0184, 8'h1C, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 13'h0000, 8'h00, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b1, 13'h0202, 8'h1C, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 13'h0000, 8'h00, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b1, 13'h0203, 8'h1C, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 13'h0000, 8'h00, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b1, 13'h0204, 8'h1C, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 13'h0000, 8'h00, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 13'h0000, 8'h00, 1'b1, 7'd5,  7'd2,   6'd0, 6'd0, 8'h77, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 13'h0000, 8'h00, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 13'h0000, 8'h00, 1'b1, 7'd78, 7'd100, 6'd59, 6'd63, 8'hAA, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 13'h0000, 8'h00, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b1, 13'h1DCE, 8'hAA, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 13'h0000, 8'h00, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b1, 13'h1DCF, 8'hAA, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 13'h0000, 8'h00, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 13'h0001, 8'h11, 1'b1, 7'd0,  7'd0,   6'd0, 6'd0, 8'h22, 1'b1, 13'h0001, 8'h11, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 13'h0000, 8'h00, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b1, 13'h0000, 8'h22, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 13'h0000, 8'h00, 1'b0, 7'd0,  7'd0,   6'd0, 6'd0, 8'h00, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b0};

    RESET = 1'b1; MCU_WE = 1'b0; MCU_WA = '0; MCU_WD = '0;
    FILL_START = 1'b0; FILL_X0 = '0; FILL_X1 = '0; FILL_Y0 = '0; FILL_Y1 = '0; FILL_COLOR = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst.we", int'(FB_WE), 0);
    check("rst.wa", int'(FB_WA), 0);
    check("rst.wd", int'(FB_WD), 0);
    check("rst.busy", int'(FILL_BUSY), 0);
    check("rst.done", int'(FILL_DONE), 0);
    RESET = 1'b0;

    for (int i = 0; i < 19; i++) begin
      MCU_WE     = tbl[i].mwe;
      MCU_WA     = tbl[i].mwa;
      MCU_WD     = tbl[i].mwd;
      FILL_START = tbl[i].fs;
      FILL_X0    = tbl[i].x0;
      FILL_X1    = tbl[i].x1;
      FILL_Y0    = tbl[i].y0;
      FILL_Y1    = tbl[i].y1;
      FILL_COLOR = tbl[i].col;
      cyc($sformatf("vec%0d", i), tbl[i].ewe, tbl[i].ewa, tbl[i].ewd, tbl[i].ebusy, tbl[i].edone);
    end

    // MCU holds the port for 3 cycles after the 2nd fill write
    set_fill(7'd2, 7'd4, 6'd3, 6'd4, 8'h1C);
    cyc("ct.start", 1'b0, 13'h0, 8'h00, 1'b1, 1'b0);
    cyc("ct.f1", 1'b1, 13'h0182, 8'h1C, 1'b1, 1'b0);
    cyc("ct.f2", 1'b1, 13'h0183, 8'h1C, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) begin
      MCU_WE = 1'b1;
      MCU_WA = 13'h0100 + 13'(j);
      MCU_WD = 8'h50 + 8'(j);
      cyc($sformatf("ct.m%0d", j), 1'b1, 13'h0100 + 13'(j), 8'h50 + 8'(j), 1'b1, 1'b0);
    end
    cyc("ct.f3", 1'b1, 13'h0184, 8'h1C, 1'b1, 1'b0);
    cyc("ct.f4", 1'b1, 13'h0202, 8'h1C, 1'b1, 1'b0);
    cyc("ct.f5", 1'b1, 13'h0203, 8'h1C, 1'b1, 1'b0);
    cyc("ct.f6", 1'b1, 13'h0204, 8'h1C, 1'b0, 1'b1);
    cyc("ct.idle", 1'b0, 13'h0, 8'h00, 1'b0, 1'b0);

    // Full-screen fill aborted by reset at the 100th write
    set_fill(7'd0, 7'd79, 6'd0, 6'd59, 8'hFF);
    cyc("fs.start", 1'b0, 13'h0, 8'h00, 1'b1, 1'b0);
    nw = 0;
    for (int c = 0; c < 200 && nw < 100; c++) begin
      @(posedge CLK);
      #1;
      if (FB_WE) begin
        check("fs.addr", int'(FB_WA), ((nw / 80) << 7) | (nw % 80));
        nw++;
      end
    end
    check("fs.count", nw, 100);
    RESET = 1'b1;
    cyc("fs.rst", 1'b0, 13'h0, 8'h00, 1'b0, 1'b0);
    RESET = 1'b0;
    cyc("fs.post1", 1'b0, 13'h0, 8'h00, 1'b0, 1'b0);
    cyc("fs.post2", 1'b0, 13'h0, 8'h00, 1'b0, 1'b0);
    set_fill(7'd1, 7'd2, 6'd1, 6'd1, 8'h33);
    cyc("rf.start", 1'b0, 13'h0, 8'h00, 1'b1, 1'b0);
    cyc("rf.f1", 1'b1, 13'h0081, 8'h33, 1'b1, 1'b0);
    cyc("rf.f2", 1'b1, 13'h0082, 8'h33, 1'b0, 1'b1);
    cyc("rf.idle", 1'b0, 13'h0, 8'h00, 1'b0, 1'b0);

    // Second START during a fill must be ignored
    set_fill(7'd10, 7'd11, 6'd5, 6'd6, 8'h44);
    cyc("sb.start", 1'b0, 13'h0, 8'h00, 1'b1, 1'b0);
    cyc("sb.f1", 1'b1, 13'h028A, 8'h44, 1'b1, 1'b0);
    set_fill(7'd0, 7'd3, 6'd0, 6'd3, 8'h55);
    cyc("sb.f2", 1'b1, 13'h028B, 8'h44, 1'b1, 1'b0);
    cyc("sb.f3", 1'b1, 13'h030A, 8'h44, 1'b1, 1'b0);
    cyc("sb.f4", 1'b1, 13'h030B, 8'h44, 1'b0, 1'b1);
    cyc("sb.idle1", 1'b0, 13'h0, 8'h00, 1'b0, 1'b0);
    cyc("sb.idle2", 1'b0, 13'h0, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
